screen_sequencer: RTL and testbench
===================================

Name: screen_sequencer

Overview:
- Central game-flow controller for the Breakout top level, replacing the ad-hoc state/score muxing around the level datapaths.
- Sequences start menu -> level select -> one of 8 levels -> game over / back to select.
- Issues one-hot level enables and a start pulse to the level engines, and keeps per-level high scores.
- Switches the VGA source select only on frame boundaries so screen changes never tear mid-frame.

Parameters:
- NUM_LEVELS, 8, number of level engines; level_en width.
- SCORE_W, 9, score width in bits.
- GO_FRAMES, 180, frames the game-over screen is held before auto-return to level select (about 3 s at 60 Hz).
- ARM_FRAMES, 2, frames after level entry during which win/lose are ignored.

Ports:
- clk  in  1  100 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- key_level  in  4  keyboard level code; 0 = none, 1..8 = level
- key_other  in  1  keyboard start/confirm/quit key (level signal)
- frame_tick  in  1  one-cycle pulse at start of each VGA frame
- win  in  1  win flag from the currently enabled level
- lose  in  1  lose flag from the currently enabled level
- score_in  in  SCORE_W  current score of the enabled level
- state  out  4  current screen state code
- src_sel  out  4  frame-aligned VGA source select (same encoding as state)
- level_en  out  NUM_LEVELS  one-hot enable; bit n-1 = level n
- game_start  out  1  one-cycle pulse on level entry (restarts that level engine)
- cur_score  out  SCORE_W  displayed current score
- high_score  out  SCORE_W  displayed high score

Behaviour:
- State encoding: SM=4'hF, LS=4'h1, GO=4'h2, L1..L8=4'h3..4'hA.
- Reset values: state=SM, src_sel=SM, level_en=0, game_start=0, cur_score=0, high_score=0, all high-score table entries 0, timers 0.
- key_other is edge-detected: one registered sample, then a rising-edge pulse.
- key_level is change-detected: an event fires when the value goes from 0 to 1..8.
- Transitions, all registered with 1-cycle latency from the input event:
  - SM: key_other edge -> LS.
  - LS: valid key_level event n (1..8) -> Ln, with game_start pulsed in the same cycle the state becomes Ln. Codes 0 and 9..15 are ignored.
  - Ln, armed: lose -> GO; win -> LS; win and lose together -> win has priority (LS). key_other edge -> LS (quit). key_level is ignored.
  - Ln, not armed: the arm counter counts frame_ticks from entry; win/lose are ignored until ARM_FRAMES ticks have been seen. This blocks stale flags left over from a previous session.
  - GO: returns to LS after GO_FRAMES frame_ticks, or on a key_other edge, whichever comes first. The counter clears on GO entry.
- Outputs derived from state:
  - level_en is the registered one-hot of state when in Ln, otherwise 0.
  - src_sel loads state only in the cycle after frame_tick and holds otherwise. With no frame_tick, src_sel never changes.
- Score handling (registered):
  - In Ln: cur_score=score_in and high_score=hs[n].
  - hs[n] updates to score_in whenever score_in > hs[n] (unsigned compare) while in Ln. A same-cycle update shows on high_score one cycle later.
  - Outside Ln: cur_score=0 and high_score=0. The table is retained.
- Counters saturate and do not wrap.
- Reset asserted mid-game: immediate return to reset values, including clearing the high-score table.

Optional Feature:
- AUTO_ADVANCE_EN defined: a win in Ln with n<8 goes directly to L(n+1), with a game_start pulse and re-arming. A win in L8 goes to LS.
- Not defined: every win goes to LS.

Decomposition:
- Shared package breakout_pkg holds:
  - state code constants SM, LS, GO, L1..L8
  - SCORE_W
  - a function mapping a level number to its state code.
- One natural sub-module: frame_counter, a frame_tick-driven saturating counter with clear and a terminal flag. It is instantiated twice, for arm and for GO hold.

Test Plan:
- Reset, then key_other pulse -> state 4'hF->4'h1 one cycle after the edge; src_sel stays 4'hF until the next frame_tick, then 4'h1.
- In LS: key_level 0->3 -> state=4'h5, level_en=8'b0000_0100, game_start high for exactly 1 cycle; key_level=4'hB -> no change.
- In L3, win held high from entry -> ignored until 2 frame_ticks; then LS. With win and lose both high after arming -> LS.
- In L5: lose after arming -> GO; 180 frame_ticks -> LS. Repeat with a key_other edge at tick 10 -> LS at tick 10.
- In L2: score_in ramps 0..40 -> high_score tracks to 40. Exit and re-enter L2 with score 25 -> high_score=40, cur_score=25. In LS both outputs read 0.
- Build with AUTO_ADVANCE_EN: win in L7 -> L8 with a game_start pulse; win in L8 -> LS. Assert rst_n low mid-L4 -> state=SM and hs table cleared on the same edge.

Source files
------------

// File: rtl/breakout_pkg.sv
// breakout_pkg: screen state codes, score width and level-to-state mapping shared by the
// Breakout game-flow logic.
package breakout_pkg;
    localparam int SCORE_W = 9;

    localparam logic [3:0] SM = 4'hF;
    localparam logic [3:0] LS = 4'h1;
    localparam logic [3:0] GO = 4'h2;
    localparam logic [3:0] L1 = 4'h3;
    localparam logic [3:0] L2 = 4'h4;
    localparam logic [3:0] L3 = 4'h5;
    localparam logic [3:0] L4 = 4'h6;
    localparam logic [3:0] L5 = 4'h7;
    localparam logic [3:0] L6 = 4'h8;
    localparam logic [3:0] L7 = 4'h9;
    localparam logic [3:0] L8 = 4'hA;

    function automatic logic [3:0] level_code(input logic [3:0] n);
        return n + 4'd2;
    endfunction

    function automatic logic is_level(input logic [3:0] s);
        return s >= L1 && s <= L8;
    endfunction
endpackage

// File: rtl/frame_counter.sv
// frame_counter: saturating frame_tick counter with synchronous clear; done_o is high once
// N ticks have been seen, including a tick arriving in the current cycle.
module frame_counter #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic clr_i,
    output logic done_o
);
    localparam int W = $clog2(N + 1);

    logic [W-1:0] cnt_q;
    logic         full;

    assign full   = cnt_q == W'(N);
    assign done_o = full || (tick_i && cnt_q == W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (tick_i && !full) cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: Breakout game-flow controller (menu, level select, 8 levels, game over).
// Define AUTO_ADVANCE_EN to move straight to the next level on a win instead of level select.
module screen_sequencer #(
    parameter int NUM_LEVELS = 8,
    parameter int SCORE_W    = breakout_pkg::SCORE_W,
    parameter int GO_FRAMES  = 180,
    parameter int ARM_FRAMES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            key_level,
    input  logic                  key_other,
    input  logic                  frame_tick,
    input  logic                  win,
    input  logic                  lose,
    input  logic [SCORE_W-1:0]    score_in,
    output logic [3:0]            state,
    output logic [3:0]            src_sel,
    output logic [NUM_LEVELS-1:0] level_en,
    output logic                  game_start,
    output logic [SCORE_W-1:0]    cur_score,
    output logic [SCORE_W-1:0]    high_score
);
    import breakout_pkg::*;

    logic [3:0]            state_q, state_d, src_sel_q, kl_q, win_state;
    logic [NUM_LEVELS-1:0] level_en_q;
    logic                  game_start_q, ko_q;
    logic [SCORE_W-1:0]    cur_score_q, high_score_q;
    logic [SCORE_W-1:0]    hs_q [NUM_LEVELS];
    logic                  ko_edge, kl_event, in_lvl, enter, go_enter, armed, go_done;
    logic [2:0]            lv;

    assign ko_edge  = key_other && !ko_q;
    assign kl_event = kl_q == 4'd0 && key_level >= 4'd1 && key_level <= 4'd8;
    assign in_lvl   = is_level(state_q);
    assign lv       = 3'(state_q - L1);
    assign enter    = is_level(state_d) && state_d != state_q;
    assign go_enter = state_d == GO && state_q != GO;

`ifdef AUTO_ADVANCE_EN
    assign win_state = (state_q == L8) ? LS : state_q + 4'd1;
`else
    assign win_state = LS;
`endif

    // Win beats lose, and both beat a quit key; unknown codes recover to the start menu.
    assign state_d = state_q == SM   ? (ko_edge ? LS : SM)
                   : state_q == LS   ? (kl_event ? level_code(key_level) : LS)
                   : state_q == GO   ? ((go_done || ko_edge) ? LS : GO)
                   : !in_lvl         ? SM
                   : (armed && win)  ? win_state
                   : (armed && lose) ? GO
                   : ko_edge         ? LS : state_q;

    frame_counter #(.N(ARM_FRAMES)) u_arm (
        .clk(clk), .rst_n(rst_n), .tick_i(frame_tick), .clr_i(enter), .done_o(armed)
    );

    frame_counter #(.N(GO_FRAMES)) u_go (
        .clk(clk), .rst_n(rst_n), .tick_i(frame_tick), .clr_i(go_enter), .done_o(go_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SM;
            src_sel_q    <= SM;
            kl_q         <= '0;
            ko_q         <= 1'b0;
            level_en_q   <= '0;
            game_start_q <= 1'b0;
            cur_score_q  <= '0;
            high_score_q <= '0;
            hs_q         <= '{default: '0};
        end else begin
            state_q      <= state_d;
            src_sel_q    <= frame_tick ? state_q : src_sel_q;
            kl_q         <= key_level;
            ko_q         <= key_other;
            level_en_q   <= is_level(state_d) ? NUM_LEVELS'(1) << (state_d - L1) : '0;
            game_start_q <= enter;
            cur_score_q  <= in_lvl ? score_in : '0;
            high_score_q <= in_lvl ? hs_q[lv] : '0;
            if (in_lvl && score_in > hs_q[lv]) hs_q[lv] <= score_in;
        end
    end

    assign state      = state_q;
    assign src_sel    = src_sel_q;
    assign level_en   = level_en_q;
    assign game_start = game_start_q;
    assign cur_score  = cur_score_q;
    assign high_score = high_score_q;
endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: scoreboard bench; a screen-level reference model predicts every cycle's
// outputs, and a monitor compares them one cycle later.
module tb_screen_sequencer;
`ifdef AUTO_ADVANCE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [3:0] key_level = '0;
    logic       key_other = 1'b0, frame_tick = 1'b0, win = 1'b0, lose = 1'b0;
    logic [8:0] score_in = '0;
    logic [3:0] state, src_sel;
    logic [7:0] level_en;
    logic       game_start;
    logic [8:0] cur_score, high_score;

    always #5 clk = ~clk;

    screen_sequencer dut (
        .clk(clk), .rst_n(rst_n), .key_level(key_level), .key_other(key_other),
        .frame_tick(frame_tick), .win(win), .lose(lose), .score_in(score_in),
        .state(state), .src_sel(src_sel), .level_en(level_en), .game_start(game_start),
        .cur_score(cur_score), .high_score(high_score)
    );

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] src;
        logic [7:0] len;
        logic       gs;
        logic [8:0] cur;
        logic [8:0] hi;
    } obs_t;

    localparam obs_t RST_OBS = '{st: 4'hF, src: 4'hF, len: 8'h0, gs: 1'b0, cur: 9'd0, hi: 9'd0};

    obs_t exp_q[$];
    int   checks = 0, failures = 0;

    // Stimulus intent, applied at the next negedge.
    logic [3:0] s_kl = '0;
    logic       s_ko = 1'b0, s_win = 1'b0, s_lose = 1'b0, rnd_tick = 1'b0;
    logic [8:0] s_score = '0;
    int         tper = 0, tcnt = 0;

    // Reference model: screen code, frames seen in the current level / game-over screen, best scores.
    int m_st, m_src, m_arm, m_go, m_cur, m_hi, m_len, m_gs, m_kl;
    bit m_ko;
    int m_hs[1:8];

    function automatic int lvl_of(input int s);
        return (s >= 3 && s <= 10) ? s - 2 : 0;
    endfunction

    function automatic obs_t outs();
        return {state, src_sel, level_en, game_start, cur_score, high_score};
    endfunction

    function automatic void chk(input string nm, input obs_t g, input obs_t e);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s t=%0t got st=%h src=%h en=%b gs=%b cur=%0d hi=%0d want st=%h src=%h en=%b gs=%b cur=%0d hi=%0d",
                     nm, $time, g.st, g.src, g.len, g.gs, g.cur, g.hi, e.st, e.src, e.len, e.gs, e.cur, e.hi);
        end
    endfunction

    task automatic model_reset();
        m_st = 15; m_src = 15; m_arm = 0; m_go = 0; m_cur = 0; m_hi = 0;
        m_len = 0; m_gs = 0; m_kl = 0; m_ko = 0;
        for (int i = 1; i <= 8; i++) m_hs[i] = 0;
    endtask

    task automatic model_step();
        int  n, nx, t;
        bit  koe, kle, enter;
        n   = lvl_of(m_st);
        nx  = m_st;
        t   = int'(frame_tick);
        koe = key_other && !m_ko;
        kle = m_kl == 0 && key_level >= 1 && key_level <= 8;
        if (m_st == 15) begin
            if (koe) nx = 1;
        end else if (m_st == 1) begin
            if (kle) nx = int'(key_level) + 2;
        end else if (m_st == 2) begin
            if (m_go + t >= 180 || koe) nx = 1;
        end else if (m_arm + t >= 2 && win) begin
            nx = (AUTO && n < 8) ? n + 3 : 1;
        end else if (m_arm + t >= 2 && lose) begin
            nx = 2;
        end else if (koe) begin
            nx = 1;
        end
        enter = lvl_of(nx) != 0 && nx != m_st;
        if (n != 0) begin
            m_cur = int'(score_in);
            m_hi  = m_hs[n];
            if (int'(score_in) > m_hs[n]) m_hs[n] = int'(score_in);
        end else begin
            m_cur = 0;
            m_hi  = 0;
        end
        m_arm = enter ? 0 : (m_arm + t > 2 ? 2 : m_arm + t);
        m_go  = (nx == 2 && m_st != 2) ? 0 : (m_go + t > 180 ? 180 : m_go + t);
        if (t != 0) m_src = m_st;
        m_len = lvl_of(nx) != 0 ? 1 << (lvl_of(nx) - 1) : 0;
        m_gs  = int'(enter);
        m_ko  = key_other;
        m_kl  = int'(key_level);
        m_st  = nx;
        exp_q.push_back('{st: 4'(m_st), src: 4'(m_src), len: 8'(m_len), gs: 1'(m_gs),
                          cur: 9'(m_cur), hi: 9'(m_hi)});
    endtask

    task automatic drive();
        key_level  = s_kl;
        key_other  = s_ko;
        win        = s_win;
        lose       = s_lose;
        score_in   = s_score;
        frame_tick = rnd_tick ? ($urandom_range(0, 3) == 0) : (tper != 0 && tcnt % tper == 0);
        tcnt++;
        model_step();
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            drive();
        end
    endtask

    task automatic enter_level(input logic [3:0] n);
        s_kl = n; step(1); s_kl = '0;
    endtask

    always @(posedge clk) begin : monitor
        obs_t e;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("outputs", outs(), e);
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset", outs(), RST_OBS);
        @(negedge clk); rst_n = 1'b1; drive();
        step(3);
        s_ko = 1'b1; step(3); s_ko = 1'b0; step(5);
        tper = 4; step(8); tper = 0;
        s_kl = 4'd11; step(3); s_kl = '0; step(2);
        enter_level(4'd3); step(2);
        s_win = 1'b1; tper = 4; step(12); s_win = 1'b0;
        enter_level(4'd3); step(12);
        s_win = 1'b1; s_lose = 1'b1; step(2); s_win = 1'b0; s_lose = 1'b0;
        enter_level(4'd5); step(12);
        s_lose = 1'b1; step(2); s_lose = 1'b0; step(740);
        enter_level(4'd5); step(12);
        s_lose = 1'b1; step(2); s_lose = 1'b0; step(40);
        s_ko = 1'b1; step(2); s_ko = 1'b0; step(4);
        enter_level(4'd2);
        for (int i = 0; i <= 40; i++) begin
            s_score = 9'(i); step(1);
        end
        s_ko = 1'b1; step(2); s_ko = 1'b0; step(3);
        s_score = 9'd25; enter_level(4'd2); step(5);
        s_ko = 1'b1; step(2); s_ko = 1'b0; step(3);
        enter_level(4'd7); step(12);
        s_win = 1'b1; step(1); s_win = 1'b0; step(12);
        s_win = 1'b1; step(1); s_win = 1'b0; step(4);
        s_ko = 1'b1; step(2); s_ko = 1'b0; step(3);
        enter_level(4'd4); s_score = 9'd77; step(10);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("async_reset", outs(), RST_OBS);
        model_reset();
        @(negedge clk); rst_n = 1'b1; drive();
        s_ko = 1'b1; step(2); s_ko = 1'b0; step(2);
        s_score = 9'd5; enter_level(4'd4); step(6);
        rnd_tick = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 29) == 0) s_ko = ~s_ko;
            if ($urandom_range(0, 5) == 0) s_kl = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 3) == 0) s_kl = '0;
            s_win  = $urandom_range(0, 39) == 0;
            s_lose = $urandom_range(0, 39) == 0;
            if ($urandom_range(0, 2) == 0) s_score = s_score + 9'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) s_score = 9'($urandom_range(0, 511));
            step(1);
        end
        s_ko = 1'b0; s_kl = '0; s_win = 1'b0; s_lose = 1'b0;
        step(3);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
